bsg_serial_less_than: RTL
=========================

// Module: bsg_serial_less_than
// PURPOSE
//  Multi-cycle LSB-first magnitude comparator. Accepts operands a_i/b_i over a
//  valid/ready handshake and compares chunk_p bits per cycle, starting at the LSB.
//  Produces lt_o (a<b) and eq_o (a==b) behind a valid/yumi handshake.
//  Replaces the flat single-cycle compare tree on timing-critical paths where
//  multi-cycle latency is acceptable.
// PARAMETERS
//  width_p  16  operand width in bits; must be a multiple of chunk_p
//  chunk_p   4  bits compared per cycle; 1 <= chunk_p <= width_p
//  (derived) els_lp = width_p/chunk_p  number of chunks = compare cycles
// PORTS
//  clk_i    in   1        single clock, all state updates on posedge
//  reset_i  in   1        synchronous, active-high reset
//  v_i      in   1        operands valid
//  ready_o  out  1        block can accept operands
//  a_i      in   width_p  operand A
//  b_i      in   width_p  operand B
//  v_o      out  1        result valid
//  lt_o     out  1        a_i < b_i of the accepted pair
//  eq_o     out  1        a_i == b_i of the accepted pair
//  yumi_i   in   1        consumer takes the result; legal only when v_o=1
// BEHAVIOUR
//  Reset: state=IDLE, v_o=0, lt_o=0, eq_o=0. ready_o=0 while reset_i=1.
//  FSM states: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: ready_o=1. On v_i&ready_o: latch a_i/b_i into shift regs, lt_r=0,
//     eq_r=1, cnt=0, go to BUSY. Otherwise stay in IDLE.
//   BUSY: ready_o=0. Each cycle, take ca/cb = low chunk_p bits of the shift regs:
//     lt_r <= (ca<cb) | ((ca==cb) & lt_r)
//     eq_r <= eq_r & (ca==cb)
//     Shift regs right by chunk_p. cnt++.
//     When cnt==els_lp-1, the chunk being processed is the last; go to DONE.
//     cnt is $clog2(els_lp) bits wide (min 1) and never wraps.
//   DONE: v_o=1; lt_o/eq_o = lt_r/eq_r, held stable. ready_o=0.
//     yumi_i -> IDLE; ready_o=1 the next cycle.
//     No accept occurs in the same cycle as yumi_i.
//  Latency: v_o rises exactly els_lp cycles after the accept edge.
//  Throughput: one compare per els_lp+2 cycles (accept, els_lp compare, yumi).
//  Outputs are registered; there is no combinational path from a_i/b_i to outputs.
//  Boundaries:
//   - v_i while not IDLE: ignored, no state change.
//   - yumi_i while v_o=0: ignored.
//   - chunk_p==width_p: BUSY lasts exactly one cycle.
//   - a==b: lt_o=0, eq_o=1.
//   - reset_i mid-BUSY or in DONE: result discarded; next cycle IDLE, v_o=0.
//  lt_o/eq_o keep their last values after yumi_i. They are meaningful only
//  while v_o=1.
// CONFIGURATION
//  BSG_SERIAL_LESS_THAN_SIGNED_EN
//   Defined: operands are two's complement. During the last chunk only, the
//     compare inverts the MSB of both ca and cb. eq_o is unaffected.
//   Undefined: unsigned compare; the last chunk is treated like every other.
// TESTING
//  1. Reset held 3 cycles -> v_o=0, ready_o=0 during reset; ready_o=1 the cycle
//     after release.
//  2. width 16/chunk 4: a=16'h1234, b=16'h1235 accepted -> v_o exactly 4 cycles
//     later, lt_o=1, eq_o=0. Result holds until yumi_i; then ready_o=1.
//  3. a=16'h8000, b=16'h7FFF: unsigned -> lt_o=0, eq_o=0.
//     With SIGNED_EN -> lt_o=1. Also a=b=16'hA5A5 -> lt_o=0, eq_o=1.
//  4. LSB-decides case a=16'h00F0, b=16'h00F1 -> lt_o=1. MSB-overrides case
//     a=16'h0100, b=16'h00FF -> lt_o=0.
//  5. v_i held high through BUSY and DONE with changing a_i, and yumi_i stalled
//     5 cycles -> only the first pair is compared; v_o/lt_o stay stable.
//  6. reset_i pulsed in BUSY cycle 2 -> v_o never asserts. A fresh pair
//     1/2 gives lt_o=1. Repeat tests 2-4 with chunk_p=1 and chunk_p=16.

Source files
------------

// File: rtl/bsg_serial_less_than.sv
// LSB-first serial magnitude comparator, chunk_p bits per cycle; `define BSG_SERIAL_LESS_THAN_SIGNED_EN for two's complement.
// Latency: v_o rises els_lp cycles after the accept edge; one compare per els_lp+2 cycles.
// Backpressure: ready_o low from accept until yumi_i; result held stable until yumi_i.
module bsg_serial_less_than #(
    parameter int width_p = 16,
    parameter int chunk_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic               v_o,
    output logic               lt_o,
    output logic               eq_o,
    input  logic               yumi_i
);

    localparam int els_lp = width_p / chunk_p;
    localparam int cnt_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
    localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(els_lp - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_r;
    logic [width_p-1:0]    a_sh_r;
    logic [width_p-1:0]    b_sh_r;
    logic [cnt_w_lp-1:0]   cnt_r;
    logic                  lt_r;
    logic                  eq_r;
    logic                  ready_r;
    logic                  v_r;
    logic                  lt_o_r;
    logic                  eq_o_r;

    logic [chunk_p-1:0]    ca;
    logic [chunk_p-1:0]    cb;
    logic [chunk_p-1:0]    ca_cmp;
    logic [chunk_p-1:0]    cb_cmp;
    logic                  is_last;
    logic                  lt_nxt;
    logic                  eq_nxt;

    assign ca      = a_sh_r[chunk_p-1:0];
    assign cb      = b_sh_r[chunk_p-1:0];
    assign is_last = (cnt_r == last_cnt_lp);

`ifdef BSG_SERIAL_LESS_THAN_SIGNED_EN
    localparam logic [chunk_p-1:0] msb_mask_lp = chunk_p'(1) << (chunk_p - 1);

    // Flipping the sign bit of the top chunk maps two's complement onto unsigned order.
    always_comb begin
        ca_cmp = ca;
        cb_cmp = cb;
        if (is_last) begin
            ca_cmp = ca ^ msb_mask_lp;
            cb_cmp = cb ^ msb_mask_lp;
        end
    end
`else
    always_comb begin
        ca_cmp = ca;
        cb_cmp = cb;
    end
`endif

    // A higher chunk that differs overrides whatever the lower chunks decided.
    assign lt_nxt = (ca_cmp < cb_cmp) | ((ca_cmp == cb_cmp) & lt_r);
    assign eq_nxt = eq_r & (ca == cb);

    assign ready_o = ready_r & ~reset_i;
    assign v_o     = v_r;
    assign lt_o    = lt_o_r;
    assign eq_o    = eq_o_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            v_r     <= 1'b0;
            lt_o_r  <= 1'b0;
            eq_o_r  <= 1'b0;
            lt_r    <= 1'b0;
            eq_r    <= 1'b1;
            cnt_r   <= '0;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b1;
                    if (v_i && ready_r) begin
                        a_sh_r  <= a_i;
                        b_sh_r  <= b_i;
                        lt_r    <= 1'b0;
                        eq_r    <= 1'b1;
                        cnt_r   <= '0;
                        ready_r <= 1'b0;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    lt_r   <= lt_nxt;
                    eq_r   <= eq_nxt;
                    a_sh_r <= a_sh_r >> chunk_p;
                    b_sh_r <= b_sh_r >> chunk_p;
                    if (is_last) begin
                        v_r     <= 1'b1;
                        lt_o_r  <= lt_nxt;
                        eq_o_r  <= eq_nxt;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + cnt_w_lp'(1);
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        v_r     <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    v_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule
